// File: rtl/duel_health_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : duel_health_arbiter
// Description : Round sequencer and hit arbiter for the two-player health
//               datapath. Owns character selection and health registers,
//               grants one hit at a time with per-player cooldown and
//               round-robin fairness, and drives the packed display word.
// Revision    : 1.0 - initial release
// ============================================================================
module duel_health_arbiter #(
    parameter int MAX_HEALTH = 10,
    parameter int COOLDOWN   = 24999999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  p1_char_sel,
    input  logic [1:0]  p2_char_sel,
    input  logic        p1_hit_req,
    input  logic [2:0]  p1_hit_dmg,
    output logic        p1_hit_ack,
    input  logic        p2_hit_req,
    input  logic [2:0]  p2_hit_dmg,
    output logic        p2_hit_ack,
    output logic [11:0] data,
    output logic [1:0]  state,
    output logic [1:0]  winner,
    output logic        round_over
);

    // Cooldown counter is sized to hold COOLDOWN; a zero cooldown still needs one bit.
    localparam int                c_CD_W       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [c_CD_W-1:0] c_CD_LOAD    = c_CD_W'(COOLDOWN);
    localparam logic [c_CD_W-1:0] c_CD_ONE     = c_CD_W'(1);
    localparam logic [3:0]        c_MAX_HEALTH = 4'(MAX_HEALTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIGHT = 2'b01,
        ST_APPLY = 2'b10,
        ST_KO    = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [1:0]          r_p1_char;
    logic [1:0]          r_p2_char;
    logic [3:0]          r_p1_health;
    logic [3:0]          r_p2_health;
    logic [c_CD_W-1:0]   r_p1_cd;
    logic [c_CD_W-1:0]   r_p2_cd;
    logic                r_p1_ack;
    logic                r_p2_ack;
    logic [1:0]          r_winner;
    logic                r_p2_priority;   // set when P1 was the most recent grantee
    logic                r_attacker_p2;   // latched attacker of the pending hit
    logic [2:0]          r_dmg;           // latched damage of the pending hit

    logic                w_p1_elig;
    logic                w_p2_elig;
    logic                w_grant_p1;
    logic                w_grant_p2;
    logic                w_start_round;
    logic [3:0]          w_target_health;
    logic [3:0]          w_new_health;

    assign w_p1_elig       = p1_hit_req && (r_p1_cd == '0);
    assign w_p2_elig       = p2_hit_req && (r_p2_cd == '0);
    assign w_target_health = r_attacker_p2 ? r_p1_health : r_p2_health;
    assign w_new_health    = (w_target_health <= {1'b0, r_dmg}) ? 4'd0
                                                                 : (w_target_health - {1'b0, r_dmg});

    // Next-state logic: round start, hit arbitration and KO detection.
    always_comb begin
        w_state_next  = r_state;
        w_grant_p1    = 1'b0;
        w_grant_p2    = 1'b0;
        w_start_round = 1'b0;
        case (r_state)
            ST_IDLE, ST_KO: begin
                if (start) begin
                    w_start_round = 1'b1;
                    w_state_next  = ST_FIGHT;
                end
            end
            ST_FIGHT: begin
                if (w_p1_elig && (!w_p2_elig || !r_p2_priority)) begin
                    w_grant_p1   = 1'b1;
                    w_state_next = ST_APPLY;
                end else if (w_p2_elig) begin
                    w_grant_p2   = 1'b1;
                    w_state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_state_next = (w_new_health == 4'd0) ? ST_KO : ST_FIGHT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Round state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One-cycle grant pulses, registered so they align with the APPLY state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_ack <= 1'b0;
            r_p2_ack <= 1'b0;
        end else begin
            r_p1_ack <= w_grant_p1;
            r_p2_ack <= w_grant_p2;
        end
    end

    // Capture the granted hit and advance the round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_attacker_p2 <= 1'b0;
            r_dmg         <= 3'd0;
            r_p2_priority <= 1'b0;
        end else if (w_grant_p1 || w_grant_p2) begin
            r_attacker_p2 <= w_grant_p2;
            r_dmg         <= w_grant_p2 ? p2_hit_dmg : p1_hit_dmg;
            r_p2_priority <= w_grant_p1;
        end
    end

    // Character, health and winner registers: reload on round start, damage in APPLY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_char   <= 2'b00;
            r_p2_char   <= 2'b00;
            r_p1_health <= c_MAX_HEALTH;
            r_p2_health <= c_MAX_HEALTH;
            r_winner    <= 2'b00;
        end else if (w_start_round) begin
            r_p1_char   <= p1_char_sel;
            r_p2_char   <= p2_char_sel;
            r_p1_health <= c_MAX_HEALTH;
            r_p2_health <= c_MAX_HEALTH;
            r_winner    <= 2'b00;
        end else if (r_state == ST_APPLY) begin
            if (r_attacker_p2) begin
                r_p1_health <= w_new_health;
            end else begin
                r_p2_health <= w_new_health;
            end
            if (w_new_health == 4'd0) begin
                r_winner <= r_attacker_p2 ? 2'b10 : 2'b01;
            end
        end
    end

    // Per-player cooldowns: load on grant, count down outside IDLE, clear on round start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_cd <= '0;
            r_p2_cd <= '0;
        end else if (w_start_round) begin
            r_p1_cd <= '0;
            r_p2_cd <= '0;
        end else begin
            if (w_grant_p1) begin
                r_p1_cd <= c_CD_LOAD;
            end else if ((r_state != ST_IDLE) && (r_p1_cd != '0)) begin
                r_p1_cd <= r_p1_cd - c_CD_ONE;
            end
            if (w_grant_p2) begin
                r_p2_cd <= c_CD_LOAD;
            end else if ((r_state != ST_IDLE) && (r_p2_cd != '0)) begin
                r_p2_cd <= r_p2_cd - c_CD_ONE;
            end
        end
    end

    assign p1_hit_ack = r_p1_ack;
    assign p2_hit_ack = r_p2_ack;
    assign data       = {r_p1_char, r_p1_health, r_p2_char, r_p2_health};
    assign state      = r_state;
    assign winner     = r_winner;
    assign round_over = (r_state == ST_KO);

endmodule
`default_nettype wire

// File: tb/tb_duel_health_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_duel_health_arbiter
// Description : Self-checking bench for duel_health_arbiter. A behavioural
//               game model tracks each player's health and cooldown and is
//               compared against the DUT on every falling clock edge;
//               directed scenarios pin the model with literal values, then
//               randomized play exercises arbitration, KO and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duel_health_arbiter;

    localparam int MAX_HEALTH = 10;
    localparam int COOLDOWN   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  p1_char_sel = 2'b00;
    logic [1:0]  p2_char_sel = 2'b00;
    logic        p1_hit_req = 1'b0;
    logic [2:0]  p1_hit_dmg = 3'd0;
    logic        p1_hit_ack;
    logic        p2_hit_req = 1'b0;
    logic [2:0]  p2_hit_dmg = 3'd0;
    logic        p2_hit_ack;
    logic [11:0] data;
    logic [1:0]  state;
    logic [1:0]  winner;
    logic        round_over;

    int checks = 0;
    int errors = 0;

    duel_health_arbiter #(
        .MAX_HEALTH (MAX_HEALTH),
        .COOLDOWN   (COOLDOWN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .p1_char_sel (p1_char_sel),
        .p2_char_sel (p2_char_sel),
        .p1_hit_req  (p1_hit_req),
        .p1_hit_dmg  (p1_hit_dmg),
        .p1_hit_ack  (p1_hit_ack),
        .p2_hit_req  (p2_hit_req),
        .p2_hit_dmg  (p2_hit_dmg),
        .p2_hit_ack  (p2_hit_ack),
        .data        (data),
        .state       (state),
        .winner      (winner),
        .round_over  (round_over)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural game model. Players are indexed 0 (P1) and 1 (P2).
    // Round phases: 0 idle, 1 fight, 2 applying a hit, 3 knocked out.
    // ------------------------------------------------------------------
    int m_phase;
    int m_char[2];
    int m_health[2];
    int m_cd[2];
    int m_ack[2];
    int m_winner;
    int m_last;      // player granted most recently, -1 for none
    int m_att;
    int m_dmg;

    task automatic model_reset();
        m_phase  = 0;
        m_winner = 0;
        m_last   = -1;
        m_att    = 0;
        m_dmg    = 0;
        for (int i = 0; i < 2; i++) begin
            m_char[i]   = 0;
            m_health[i] = MAX_HEALTH;
            m_cd[i]     = 0;
            m_ack[i]    = 0;
        end
    endtask

    task automatic cool_down();
        for (int i = 0; i < 2; i++) if (m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
    endtask

    task automatic model_step();
        int req[2];
        int dmg[2];
        int g;
        int t;
        int h;
        req[0] = int'(p1_hit_req);
        req[1] = int'(p2_hit_req);
        dmg[0] = int'(p1_hit_dmg);
        dmg[1] = int'(p2_hit_dmg);
        m_ack[0] = 0;
        m_ack[1] = 0;
        if ((m_phase == 0 || m_phase == 3) && start) begin
            m_char[0] = int'(p1_char_sel);
            m_char[1] = int'(p2_char_sel);
            for (int i = 0; i < 2; i++) begin
                m_health[i] = MAX_HEALTH;
                m_cd[i]     = 0;
            end
            m_winner = 0;
            m_phase  = 1;
        end else if (m_phase == 3) begin
            cool_down();
        end else if (m_phase == 1) begin
            g = -1;
            if (req[0] != 0 && m_cd[0] == 0 && req[1] != 0 && m_cd[1] == 0)
                g = (m_last == 0) ? 1 : 0;
            else if (req[0] != 0 && m_cd[0] == 0)
                g = 0;
            else if (req[1] != 0 && m_cd[1] == 0)
                g = 1;
            cool_down();
            if (g >= 0) begin
                m_ack[g] = 1;
                m_att    = g;
                m_dmg    = dmg[g];
                m_cd[g]  = COOLDOWN;
                m_last   = g;
                m_phase  = 2;
            end
        end else if (m_phase == 2) begin
            t = 1 - m_att;
            h = m_health[t] - m_dmg;
            if (h < 0) h = 0;
            m_health[t] = h;
            cool_down();
            if (h == 0) begin
                m_winner = m_att + 1;
                m_phase  = 3;
            end else begin
                m_phase = 1;
            end
        end
    endtask

    function automatic logic [11:0] model_data();
        return {2'(m_char[0]), 4'(m_health[0]), 2'(m_char[1]), 4'(m_health[1])};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_state",      32'(state),      32'(m_phase));
            chk("model_data",       32'(data),       32'(model_data()));
            chk("model_p1_ack",     32'(p1_hit_ack), 32'(m_ack[0]));
            chk("model_p2_ack",     32'(p2_hit_ack), 32'(m_ack[1]));
            chk("model_winner",     32'(winner),     32'(m_winner));
            chk("model_round_over", 32'(round_over), 32'(m_phase == 3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a grant to the given player (1 or 2).
    task automatic wait_ack(input string name, input int p, input int budget);
        int n;
        logic a;
        n = 0;
        do begin
            tick();
            n++;
            a = (p == 1) ? p1_hit_ack : p2_hit_ack;
        end while (a !== 1'b1 && n < budget);
        chk(name, 32'(a), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic begin_round(input logic [1:0] c1, input logic [1:0] c2);
        start       = 1'b1;
        p1_char_sel = c1;
        p2_char_sel = c2;
        tick();
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state and ignored requests in IDLE.
        repeat (3) tick();
        chk("rst_data",       32'(data),       32'h28A);
        chk("rst_state",      32'(state),      32'h0);
        chk("rst_p1_ack",     32'(p1_hit_ack), 32'h0);
        chk("rst_p2_ack",     32'(p2_hit_ack), 32'h0);
        chk("rst_winner",     32'(winner),     32'h0);
        chk("rst_round_over", 32'(round_over), 32'h0);
        reset_n    = 1'b1;
        p1_hit_req = 1'b1; p1_hit_dmg = 3'd5;
        p2_hit_req = 1'b1; p2_hit_dmg = 3'd1;
        repeat (3) begin
            tick();
            chk("idle_no_ack", 32'({p1_hit_ack, p2_hit_ack}), 32'h0);
        end
        chk("idle_state", 32'(state), 32'h0);
        p1_hit_req = 1'b0;
        p2_hit_req = 1'b0;

        // Round start latches characters.
        begin_round(2'b01, 2'b10);
        chk("start_state", 32'(state), 32'h1);
        chk("start_data",  32'(data),  32'h6AA);

        // Single hit and held-request re-grant after cooldown.
        p1_hit_req = 1'b1; p1_hit_dmg = 3'd3;
        tick();
        chk("hit_ack_k",   32'(p1_hit_ack), 32'h1);
        chk("hit_state_k", 32'(state),      32'h2);
        tick();
        chk("hit_ack_k1",  32'(p1_hit_ack), 32'h0);
        chk("hit_data_k1", 32'(data),       32'h6A7);
        chk("hit_state_k1", 32'(state),     32'h1);
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk("regrant_ack", 32'(p1_hit_ack), (j == 5) ? 32'h1 : 32'h0);
        end
        p1_hit_req = 1'b0;
        tick();
        chk("regrant_data", 32'(data), 32'h6A4);

        // Simultaneous requests after a fresh reset: P1 first, then P2.
        do_reset();
        begin_round(2'b01, 2'b10);
        p1_hit_req = 1'b1; p1_hit_dmg = 3'd2;
        p2_hit_req = 1'b1; p2_hit_dmg = 3'd2;
        tick();
        chk("rr_p1_ack", 32'({p1_hit_ack, p2_hit_ack}), 32'h2);
        p1_hit_req = 1'b0;
        tick();
        chk("rr_gap_ack", 32'({p1_hit_ack, p2_hit_ack}), 32'h0);
        chk("rr_data1",   32'(data), 32'h6A8);
        tick();
        chk("rr_p2_ack", 32'({p1_hit_ack, p2_hit_ack}), 32'h1);
        p2_hit_req = 1'b0;
        tick();
        chk("rr_p2_ack_drop", 32'(p2_hit_ack), 32'h0);
        chk("rr_data2",       32'(data),       32'h628);

        // Knockout with saturating damage.
        p1_hit_req = 1'b1; p1_hit_dmg = 3'd6;
        wait_ack("ko_setup_ack", 1, 10);
        p1_hit_req = 1'b0;
        tick();
        chk("ko_setup_data", 32'(data), 32'h622);
        p1_hit_req = 1'b1; p1_hit_dmg = 3'd7;
        wait_ack("ko_hit_ack", 1, 10);
        p1_hit_req = 1'b0;
        tick();
        chk("ko_data",       32'(data),       32'h620);
        chk("ko_state",      32'(state),      32'h3);
        chk("ko_winner",     32'(winner),     32'h1);
        chk("ko_round_over", 32'(round_over), 32'h1);
        p1_hit_req = 1'b1; p2_hit_req = 1'b1;
        repeat (6) begin
            tick();
            chk("ko_no_ack", 32'({p1_hit_ack, p2_hit_ack}), 32'h0);
        end
        p1_hit_req = 1'b0; p2_hit_req = 1'b0;
        begin_round(2'b11, 2'b00);
        chk("restart_data",   32'(data),   32'hE8A);
        chk("restart_winner", 32'(winner), 32'h0);
        chk("restart_state",  32'(state),  32'h1);

        // Asynchronous reset in the middle of APPLY discards the hit.
        p2_hit_req = 1'b1; p2_hit_dmg = 3'd5;
        tick();
        chk("areset_pre_ack", 32'(p2_hit_ack), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("areset_ack",   32'(p2_hit_ack), 32'h0);
        chk("areset_data",  32'(data),       32'h28A);
        chk("areset_state", 32'(state),      32'h0);
        p2_hit_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("areset_after_data", 32'(data), 32'h28A);

        // Randomized play against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
            end
            start       = ($urandom_range(0, 15) == 0);
            p1_char_sel = 2'($urandom_range(0, 3));
            p2_char_sel = 2'($urandom_range(0, 3));
            if (p1_hit_req && m_ack[0] != 0) begin
                if ($urandom_range(0, 3) != 0) p1_hit_req = 1'b0;
            end else if (!p1_hit_req && $urandom_range(0, 2) == 0) begin
                p1_hit_req = 1'b1;
                p1_hit_dmg = 3'($urandom_range(0, 7));
            end
            if (p2_hit_req && m_ack[1] != 0) begin
                if ($urandom_range(0, 3) != 0) p2_hit_req = 1'b0;
            end else if (!p2_hit_req && $urandom_range(0, 2) == 0) begin
                p2_hit_req = 1'b1;
                p2_hit_dmg = 3'($urandom_range(0, 7));
            end
        end
        start      = 1'b0;
        reset_n    = 1'b1;
        p1_hit_req = 1'b0;
        p2_hit_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
